// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//
// Four-source interrupt controller sitting between the input-port peripherals
// and the CPU core. Rising edges on irq_in are latched as pending. One enabled
// source is picked round-robin and offered to the CPU as a fixed vector over an
// int_req/int_ack handshake. No further interrupt is offered until the CPU
// strobes reti. Only one source is ever in service (no nesting).
//
// Parameters
//   ADDR_W    width of the CPU program address / vector
//   VEC_BASE  vector of source 0; source i vectors to VEC_BASE + i (mod 2^ADDR_W)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   irq_in   in   [3:0] request lines; a rising edge is a request
//   mask_we  in   mask write strobe
//   mask_wd  in   [3:0] new mask, 1 = source enabled
//   int_req  out  interrupt request to the CPU
//   int_ack  in   CPU acknowledge, only honoured while int_req=1
//   int_vec  out  [ADDR_W-1:0] vector of the granted source
//   int_id   out  [1:0] index of the granted / in-service source
//   reti     in   return-from-interrupt strobe, only honoured while busy=1
//   pending  out  [3:0] pending register (status)
//   busy     out  1 while a source is in service
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3F0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        irq_in,
    input  logic              mask_we,
    input  logic [3:0]        mask_wd,
    output logic              int_req,
    input  logic              int_ack,
    output logic [ADDR_W-1:0] int_vec,
    output logic [1:0]        int_id,
    input  logic              reti,
    output logic [3:0]        pending,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        irq_prev_reg;
    logic [3:0]        pending_reg;
    logic [3:0]        pending_next;
    logic [3:0]        mask_reg;
    logic [1:0]        last_reg;
    logic [1:0]        last_next;
    logic [1:0]        int_id_reg;
    logic [1:0]        int_id_next;
    logic [ADDR_W-1:0] int_vec_reg;
    logic [ADDR_W-1:0] int_vec_next;

    // -------------------------------------------------------------------------
    // Datapath signals
    // -------------------------------------------------------------------------
    logic [3:0]        rise;
    logic [3:0]        eligible;
    logic [3:0]        clr_mask;
    logic [1:0]        cand_idx [4];
    logic              winner_found;
    logic [1:0]        winner_idx;
    logic              grant;
    logic              ack_take;

    // Edge detect. irq_prev resets to all-ones so that lines already high when
    // reset is released are not mistaken for fresh requests.
    assign rise     = irq_in & ~irq_prev_reg;

    // Eligibility uses the registered mask, so a mask write only takes effect
    // from the cycle after the write edge.
    assign eligible = pending_reg & mask_reg;

    // Round-robin search order: last+1, last+2, last+3, last (2-bit wrap).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        winner_found = 1'b0;
        winner_idx   = last_reg;
        for (int j = 0; j < 4; j++) begin
            if (!winner_found && eligible[cand_idx[j]]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx[j];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        ack_take   = 1'b0;
        int_req    = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (winner_found) begin
                    grant      = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                int_req = 1'b1;
                if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                busy = 1'b1;
                if (reti) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register next-value logic
    // -------------------------------------------------------------------------
    // Acknowledge clears the granted bit; a new edge in the same cycle wins,
    // so the OR with rise comes last.
    assign clr_mask     = ack_take ? (4'b0001 << int_id_reg) : 4'b0000;
    assign pending_next = (pending_reg & ~clr_mask) | rise;

    assign last_next    = ack_take ? int_id_reg : last_reg;

    // Winner and vector are captured once on grant and frozen through REQ and
    // SERVICE, so later mask writes or new edges cannot change them.
    assign int_id_next  = grant ? winner_idx : int_id_reg;
    assign int_vec_next = grant ? (VEC_BASE + ADDR_W'(winner_idx)) : int_vec_reg;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            irq_prev_reg <= 4'b1111;
            pending_reg  <= 4'b0000;
            mask_reg     <= 4'b0000;
            last_reg     <= 2'd3;
            int_id_reg   <= 2'd0;
            int_vec_reg  <= VEC_BASE;
        end else begin
            state_reg    <= state_next;
            irq_prev_reg <= irq_in;
            pending_reg  <= pending_next;
            if (mask_we) begin
                mask_reg <= mask_wd;
            end
            last_reg     <= last_next;
            int_id_reg   <= int_id_next;
            int_vec_reg  <= int_vec_next;
        end
    end

    assign pending = pending_reg;
    assign int_id  = int_id_reg;
    assign int_vec = int_vec_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//
// Self-checking bench for int_ctrl. Expected grants (id, vector) are pushed to
// a scoreboard queue when the stimulus that causes them is driven, and popped
// and compared when the DUT raises int_req. Status outputs (pending, busy,
// int_req) are checked directly at the cycles where their value is known.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [1:0]        id;
        logic [ADDR_W-1:0] vec;
    } grant_t;

    logic              clk;
    logic              reset;
    logic [3:0]        irq_in;
    logic              mask_we;
    logic [3:0]        mask_wd;
    logic              int_req;
    logic              int_ack;
    logic [ADDR_W-1:0] int_vec;
    logic [1:0]        int_id;
    logic              reti;
    logic [3:0]        pending;
    logic              busy;

    grant_t sb_q [$];
    int     n_checks = 0;
    int     n_errors = 0;

    int_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .int_req (int_req),
        .int_ack (int_ack),
        .int_vec (int_vec),
        .int_id  (int_id),
        .reti    (reti),
        .pending (pending),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [ADDR_W-1:0] vec);
        grant_t e;
        e.id  = id;
        e.vec = vec;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for int_req, then compare the grant against the scoreboard.
    task automatic wait_req(input int budget);
        grant_t e;
        int     n = 0;
        while (int_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("req_seen", int_req, 1);
        if (sb_q.size() == 0) begin
            chk("sb_size", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk("grant_id", int_id, e.id);
            chk("grant_vec", int_vec, e.vec);
        end
    endtask

    // Acknowledge the current request, check service state, then return.
    task automatic serve(input logic [3:0] exp_pend);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_busy", busy, 1);
        chk("ack_req", int_req, 0);
        chk("ack_pend", pending, exp_pend);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("reti_busy", busy, 0);
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic do_reset(input logic [3:0] irq_hold);
        irq_in  = irq_hold;
        reset   = 1'b0;
        #23;
        reset   = 1'b1;
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        irq_in  = 4'b0000;
        mask_we = 1'b0;
        mask_wd = 4'b0000;
        int_ack = 1'b0;
        reti    = 1'b0;

        // ---------------- reset values, lines high through release ----------
        irq_in = 4'b1111;
        reset  = 1'b0;
        #13;
        chk("rst_req", int_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", int_id, 0);
        chk("rst_vec", int_vec, 10'h3F0);
        chk("rst_pend", pending, 0);
        #10;
        reset = 1'b1;
        tick();
        write_mask(4'b1111);
        for (int i = 0; i < 4; i++) tick();
        chk("hold_pend", pending, 0);
        chk("hold_req", int_req, 0);
        irq_in = 4'b0000;
        tick();

        // ---------------- single source -----------------------------------
        write_mask(4'b0001);
        irq_in = 4'b0001;
        push_grant(2'd0, 10'h3F0);
        tick();                         // edge k
        chk("single_pend_k", pending, 4'b0001);
        chk("single_req_k", int_req, 0);
        irq_in = 4'b0000;
        tick();                         // edge k+1
        chk("single_req_k1", int_req, 1);
        wait_req(0);
        serve(4'b0000);

        // ---------------- round robin --------------------------------------
        do_reset(4'b0000);
        write_mask(4'b1111);
        irq_in = 4'b1111;
        for (int i = 0; i < 4; i++) push_grant(2'(i), 10'h3F0 + 10'(i));
        tick();
        irq_in = 4'b0000;
        wait_req(10); serve(4'b1110);
        wait_req(10); serve(4'b1100);
        wait_req(10); serve(4'b1000);
        wait_req(10); serve(4'b0000);
        // last is 3 now: 0 must win over 2
        irq_in = 4'b0101;
        push_grant(2'd0, 10'h3F0);
        push_grant(2'd2, 10'h3F2);
        tick();
        irq_in = 4'b0000;
        wait_req(10); serve(4'b0100);
        wait_req(10); serve(4'b0000);

        // ---------------- masking ------------------------------------------
        write_mask(4'b0000);
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        chk("mask_pend", pending, 4'b0100);
        chk("mask_noreq", int_req, 0);
        push_grant(2'd2, 10'h3F2);
        write_mask(4'b0100);            // edge k
        chk("mask_req_k", int_req, 0);
        tick();                         // edge k+1
        chk("mask_req_k1", int_req, 1);
        wait_req(0);

        // ---------------- ignored inputs / frozen winner (in REQ) ----------
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("reti_in_req_req", int_req, 1);
        chk("reti_in_req_busy", busy, 0);
        write_mask(4'b0000);
        chk("maskw_req_id", int_id, 2'd2);
        chk("maskw_req_vec", int_vec, 10'h3F2);
        chk("maskw_req_req", int_req, 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("svc_busy", busy, 1);
        // new edge during SERVICE: pending only
        write_mask(4'b0010);
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        push_grant(2'd1, 10'h3F1);
        for (int i = 0; i < 3; i++) tick();
        chk("svc_pend", pending, 4'b0010);
        chk("svc_noreq", int_req, 0);
        chk("svc_id", int_id, 2'd2);
        reti = 1'b1;
        tick();                         // edge r
        reti = 1'b0;
        chk("reti_r_busy", busy, 0);
        chk("reti_r_req", int_req, 0);
        tick();                         // edge r+1
        chk("reti_r1_req", int_req, 1);
        wait_req(0);
        serve(4'b0000);

        // ack in IDLE must not clear pending
        write_mask(4'b0000);
        irq_in = 4'b1000;
        tick();
        irq_in = 4'b0000;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_idle_pend", pending, 4'b1000);
        chk("ack_idle_busy", busy, 0);
        chk("ack_idle_req", int_req, 0);

        // ---------------- async reset while int_req=1 ----------------------
        push_grant(2'd3, 10'h3F3);
        write_mask(4'b1000);
        wait_req(5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", int_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pend", pending, 0);
        chk("arst_vec", int_vec, 10'h3F0);
        chk("arst_id", int_id, 0);
        #15;
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_req", int_req, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Four-source interrupt controller between the CPU's input-port peripherals and the CPU core. It detects rising edges on four request lines, latches them as pending, and selects one enabled source round-robin. It then presents a fixed vector to the CPU over a req/ack handshake and holds off further interrupts until the CPU signals return-from-interrupt. Non-nesting: at most one source is in service at a time.

## Interface

- ADDR_W, 10, width of the CPU program address / vector.
- VEC_BASE, 10'h3F0, vector of source 0; source i vectors to VEC_BASE + i.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  4  interrupt request lines, synchronous to clk; rising edge = request.
- mask_we  in  1  mask write strobe.
- mask_wd  in  4  new mask value, 1 = source enabled; loaded when mask_we=1.
- int_req  out  1  interrupt request to the CPU.
- int_ack  in  1  CPU acknowledge; sampled only while int_req=1.
- int_vec  out  ADDR_W  vector of the granted source; valid while int_req=1.
- int_id  out  2  index of the granted/in-service source.
- reti  in  1  return-from-interrupt strobe; sampled only in SERVICE.
- pending  out  4  pending register, for status reads.
- busy  out  1  1 while a source is in service.

## Operation

- Edge detect: irq_prev <= irq_in every cycle. rise = irq_in & ~irq_prev.
- Pending: pending[i] is set on rise[i], whatever the mask. It is cleared when source i is acknowledged. A set and clear on the same bit in the same cycle leaves the bit set (the new edge is kept).
- Mask: mask <= mask_wd on mask_we. eligible = pending & mask, using the registered mask.
- Round-robin: last register (2 bits). Search order is last+1, last+2, last+3, last; the first eligible source wins.
- FSM, 3 states:
  - IDLE: int_req=0, busy=0. If eligible != 0, latch the winner into int_id, drive int_vec = VEC_BASE + winner, and go to REQ.
  - REQ: int_req=1. int_id and int_vec are frozen. Mask changes and new pending bits do not alter the winner. On int_ack: clear pending[int_id], set last <= int_id, go to SERVICE.
  - SERVICE: int_req=0, busy=1, int_id holds. On reti: go to IDLE.
- Ignored inputs: int_ack outside REQ; reti outside SERVICE.
- Edges arriving during REQ or SERVICE only set pending. They are arbitrated after return to IDLE.
- Vector arithmetic is ADDR_W bits, unsigned, and wraps modulo 2^ADDR_W.

## Timing

- Reset values (asynchronous, while reset=0):
  - state IDLE; int_req 0, busy 0, int_id 0, int_vec VEC_BASE.
  - pending 0; mask 4'b0000 (all disabled).
  - last 2'd3, so source 0 has first priority.
  - irq_prev 4'b1111, so lines already high at reset release do not create requests.
- Latency with irq_in[i] high before edge k, its mask bit set and the FSM idle:
  - pending[i] visible after edge k.
  - int_req=1 and int_vec valid after edge k+1 (2 edges).
- Handshake:
  - int_ack=1 at edge m gives int_req=0, busy=1 and pending[int_id]=0 after edge m.
  - reti=1 at edge r gives busy=0 after edge r.
  - The next int_req can rise at the earliest after edge r+1.
- A mask write at edge k affects eligibility from the cycle after edge k.
- Reset asserted mid-handshake, in any state, returns all outputs to their reset values immediately.

## Test plan

- Single source: mask=4'b0001, pulse irq_in[0].
  - int_req rises 2 edges after the rising edge, with int_vec=10'h3F0 and int_id=0.
  - After ack: busy=1 and pending=0. After reti: busy=0.
- Round-robin: mask=4'b1111, all four lines rise together.
  - Grant order 0,1,2,3 with int_vec 3F0, 3F1, 3F2, 3F3.
  - Then pulse lines 0 and 2 together: source 0 is granted first, because last=3.
- Masking: mask=0, pulse irq_in[2].
  - pending=4'b0100 and int_req stays 0.
  - Write mask=4'b0100: int_req=1 with int_vec=10'h3F2 two edges after the mask write.
- Ignored handshake inputs and frozen winner:
  - int_ack in IDLE and reti in REQ leave the state unchanged.
  - A new edge on irq_in[1] during SERVICE sets pending[1] and is granted only after reti.
  - A mask write during REQ does not change int_id.
- Reset behaviour:
  - Hold irq_in=4'b1111 through reset release: no request is generated.
  - Assert reset while int_req=1: int_req, busy and pending all drop to 0 asynchronously.
